// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback (A) has fixed priority, the
// long-latency unit (B) is forced through after STARVE_LIMIT waits. Scoreboard under WB_SCOREBOARD_EN.
module regfile_wb_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a_valid,
  input  logic [4:0]  a_addr,
  input  logic [31:0] a_data,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [4:0]  b_addr,
  input  logic [31:0] b_data,
  output logic        b_ready,
  input  logic        iss_valid,
  input  logic [4:0]  iss_addr,
  output logic [31:0] pend,
  output logic        rf_en,
  output logic        rf_wr,
  output logic [4:0]  rf_addr,
  output logic [31:0] rf_data
);

  localparam logic STATE_A_PRI   = 1'b0;
  localparam logic STATE_B_FORCE = 1'b1;
  localparam logic [3:0] STARVE_LAST = 4'(STARVE_LIMIT - 1);

  logic       state, state_next;
  logic [3:0] starve_cnt, starve_cnt_next;
  logic [4:0] win_addr;
  logic [31:0] win_data;

  // Grants depend only on the valids and registered state, never on address/data.
  assign a_ready = (state == STATE_A_PRI) & a_valid;
  assign b_ready = (state == STATE_A_PRI) ? (b_valid & ~a_valid) : b_valid;

  always_comb begin
    state_next      = STATE_A_PRI;
    starve_cnt_next = 4'd0;
    if (state == STATE_A_PRI && a_valid && b_valid) begin
      if (starve_cnt == STARVE_LAST) begin
        state_next = STATE_B_FORCE;
      end else begin
        starve_cnt_next = starve_cnt + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= STATE_A_PRI;
      starve_cnt <= 4'd0;
    end else begin
      state      <= state_next;
      starve_cnt <= starve_cnt_next;
    end
  end

  assign win_addr = a_ready ? a_addr : b_addr;
  assign win_data = a_ready ? a_data : b_data;

  // A write to r0 still updates addr/data so the port mirrors the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_en   <= 1'b0;
      rf_addr <= 5'd0;
      rf_data <= 32'd0;
    end else if (a_ready || b_ready) begin
      rf_en   <= (win_addr != 5'd0);
      rf_addr <= win_addr;
      rf_data <= win_data;
    end else begin
      rf_en   <= 1'b0;
    end
  end

  assign rf_wr = rf_en;

`ifdef WB_SCOREBOARD_EN
  logic [31:0] pend_q, pend_set, pend_clr;

  // Set is applied after clear so a fresh issue outlives the retiring result.
  always_comb begin
    pend_set = 32'd0;
    pend_clr = 32'd0;
    if (iss_valid && iss_addr != 5'd0) pend_set = 32'd1 << iss_addr;
    if (b_ready) pend_clr = 32'd1 << b_addr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend_q <= 32'd0;
    else        pend_q <= (pend_q & ~pend_clr) | pend_set;
  end

  assign pend = pend_q;
`else
  logic unused_iss;
  assign unused_iss = ^{iss_valid, iss_addr};
  assign pend = 32'd0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed vectors, expected writes
// queued by the stimulus and popped by a monitor whenever the port writes.
module tb_regfile_wb_arbiter;

`ifdef WB_SCOREBOARD_EN
  localparam logic [31:0] SB_MASK = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] SB_MASK = 32'h0000_0000;
`endif

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic        clk;
  logic        rst_n;
  logic        a_valid, b_valid, iss_valid;
  logic [4:0]  a_addr, b_addr, iss_addr;
  logic [31:0] a_data, b_data;
  logic        a_ready, b_ready;
  logic [31:0] pend;
  logic        rf_en, rf_wr;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;

  int n_vectors = 0;
  int n_miscompares = 0;
  wr_t exp_q[$];

  regfile_wb_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .iss_valid(iss_valid), .iss_addr(iss_addr), .pend(pend),
    .rf_en(rf_en), .rf_wr(rf_wr), .rf_addr(rf_addr), .rf_data(rf_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_vectors++;
    if (actual !== expected) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // One cycle: drive inputs, check grants and pend mid-cycle, queue the expected write.
  task automatic applyStimulus(
    input logic av, input logic [4:0] aa, input logic [31:0] ad,
    input logic bv, input logic [4:0] ba, input logic [31:0] bd,
    input logic iv, input logic [4:0] ia,
    input logic exp_a, input logic exp_b, input logic [31:0] exp_pend);
    wr_t w;
    a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
    iss_valid = iv; iss_addr = ia;
    @(negedge clk);
    checkOutput("a_ready", {31'd0, a_ready}, {31'd0, exp_a});
    checkOutput("b_ready", {31'd0, b_ready}, {31'd0, exp_b});
    checkOutput("pend", pend, exp_pend & SB_MASK);
    if (exp_a && aa != 5'd0) begin
      w.addr = aa; w.data = ad; exp_q.push_back(w);
    end else if (exp_b && ba != 5'd0) begin
      w.addr = ba; w.data = bd; exp_q.push_back(w);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [31:0] exp_pend);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, exp_pend);
  endtask

  // Monitor: every enabled write must match the oldest queued expectation.
  always begin
    wr_t w;
    @(posedge clk);
    #1;
    if (rst_n && rf_en) begin
      if (exp_q.size() == 0) begin
        n_vectors++;
        n_miscompares++;
        $display("[TB] FAIL unexpected_write: got addr %0d data 0x%08h expected no write at %0t",
                 rf_addr, rf_data, $time);
      end else begin
        w = exp_q.pop_front();
        checkOutput("rf_addr", {27'd0, rf_addr}, {27'd0, w.addr});
        checkOutput("rf_data", rf_data, w.data);
        checkOutput("rf_wr", {31'd0, rf_wr}, 32'd1);
      end
    end
  end

  initial begin
    int a_idx;
    logic exp_a;
    logic bv;
    rst_n = 1'b0;
    a_valid = 0; a_addr = 0; a_data = 0;
    b_valid = 0; b_addr = 0; b_data = 0;
    iss_valid = 0; iss_addr = 0;
    #1;
    checkOutput("reset_rf_en", {31'd0, rf_en}, 32'd0);
    checkOutput("reset_rf_addr", {27'd0, rf_addr}, 32'd0);
    checkOutput("reset_rf_data", rf_data, 32'd0);
    checkOutput("reset_pend", pend, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // A only, then scoreboard set / set-wins / clear
    idle(32'd0);
    applyStimulus(1, 5'd3, 32'h1234_5678, 0, 0, 0, 0, 0, 1, 0, 32'd0);
    idle(32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd7, 0, 0, 32'd0);
    idle(32'h0000_0080);
    applyStimulus(0, 0, 0, 1, 5'd7, 32'hAAAA_0007, 1, 5'd7, 0, 1, 32'h0000_0080);
    idle(32'h0000_0080);
    applyStimulus(0, 0, 0, 1, 5'd7, 32'hBBBB_0007, 0, 0, 0, 1, 32'h0000_0080);
    idle(32'd0);

    // B writes r0 with an r0 issue: handshake, no strobe, pend untouched
    applyStimulus(0, 0, 0, 1, 5'd0, 32'hFFFF_FFFF, 1, 5'd0, 0, 1, 32'd0);
    checkOutput("r0_rf_en", {31'd0, rf_en}, 32'd0);
    checkOutput("r0_rf_wr", {31'd0, rf_wr}, 32'd0);
    checkOutput("r0_rf_addr", {27'd0, rf_addr}, 32'd0);
    checkOutput("r0_rf_data", rf_data, 32'hFFFF_FFFF);
    idle(32'd0);

    // Continuous conflict: four A grants, one forced B, repeat
    a_idx = 0;
    for (int k = 0; k < 10; k++) begin
      exp_a = (k != 4) && (k != 9);
      applyStimulus(1, 5'(10 + a_idx), 32'hA000_0000 + 32'(a_idx),
                    1, 5'd9, 32'hB000_0009, 0, 0, exp_a, ~exp_a, 32'd0);
      if (exp_a) a_idx++;
    end
    idle(32'd0);

    // B withdraws during its forced cycle: port idles, then A resumes
    a_idx = 0;
    for (int k = 0; k < 5; k++) begin
      exp_a = (k < 4);
      bv = (k < 4);
      applyStimulus(1, 5'(20 + a_idx), 32'hC000_0000 + 32'(a_idx),
                    bv, 5'd9, 32'hB000_0019, 0, 0, exp_a, 0, 32'd0);
      if (exp_a) a_idx++;
    end
    checkOutput("withdraw_rf_en", {31'd0, rf_en}, 32'd0);
    checkOutput("hold_rf_addr", {27'd0, rf_addr}, 32'd23);
    checkOutput("hold_rf_data", rf_data, 32'hC000_0003);
    applyStimulus(1, 5'd24, 32'hC000_0004, 0, 0, 0, 0, 0, 1, 0, 32'd0);
    idle(32'd0);

    // Reset asserted mid-grant: outputs clear at once and the r5 write is dropped
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd4, 0, 0, 32'd0);
    a_valid = 1; a_addr = 5'd5; a_data = 32'hDEAD_BEEF;
    @(negedge clk);
    checkOutput("rst_a_ready", {31'd0, a_ready}, 32'd1);
    checkOutput("rst_pend_before", pend, 32'h0000_0010 & SB_MASK);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_rf_en", {31'd0, rf_en}, 32'd0);
    checkOutput("rst_rf_addr", {27'd0, rf_addr}, 32'd0);
    checkOutput("rst_rf_data", rf_data, 32'd0);
    checkOutput("rst_pend", pend, 32'd0);
    a_valid = 0; a_addr = 0; a_data = 0;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("post_rst_rf_en", {31'd0, rf_en}, 32'd0);
    idle(32'd0);
    idle(32'd0);

    @(posedge clk);
    #2;
    checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
